// File: rtl/data_frame_sr_if.sv
`default_nettype none
// ============================================================================
// Module   : data_frame_sr_if
// Brief    : Serial-in / frame-out bundle for data_frame_sr.
//            slave = receiver side, master = line sampler + frame consumer.
// Revision : 1.0
// ============================================================================
interface data_frame_sr_if #(
    parameter int DATA_W = 64,
    parameter int CRC_W  = 16
);
    logic              in_data;
    logic              data_shift;
    logic              SR_select;
    logic              clear;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] data;
    logic [CRC_W-1:0]  CRC_data;
    logic              overrun;
    logic              crc_ok;

    modport master (
        output in_data, data_shift, SR_select, clear, out_ready,
        input  out_valid, data, CRC_data, overrun, crc_ok
    );

    modport slave (
        input  in_data, data_shift, SR_select, clear, out_ready,
        output out_valid, data, CRC_data, overrun, crc_ok
    );
endinterface
`default_nettype wire

// File: rtl/data_frame_sr.sv
`default_nettype none
// ============================================================================
// Module   : data_frame_sr
// Brief    : Serial-to-parallel frame receiver (data | CRC | trailer) with a
//            valid/ready output stage and sticky overrun flag.
//            Optional CRC16 check: define DATA_FRAME_SR_CRC_CHECK_EN.
// Revision : 1.0
// ============================================================================
module data_frame_sr #(
    parameter int DATA_W    = 64,
    parameter int CRC_W     = 16,
    parameter int TRAIL_W   = 2,
    parameter int MSB_FIRST = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    data_frame_sr_if.slave bus
);
    localparam int FRAME_W = DATA_W + CRC_W + TRAIL_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data_sr;
    logic [CRC_W-1:0]  r_crc_sr;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_data;
    logic [CRC_W-1:0]  r_crc_data;
    logic              r_overrun;

    logic              w_sample;
    logic              w_last;
    logic              w_complete;
    logic              w_load;
    logic [DATA_W-1:0] w_data_next;
    logic [CRC_W-1:0]  w_crc_next;

    // clear has priority over a strobe in the same cycle
    assign w_sample   = bus.data_shift & bus.SR_select & ~bus.clear;
    assign w_last     = (r_cnt == CNT_W'(FRAME_W - 1));
    assign w_complete = w_sample & w_last;
    assign w_load     = w_complete & ~(r_out_valid & ~bus.out_ready);

    // The arriving bit is merged combinationally so a frame whose last field
    // bit is also the final frame bit still loads complete.
    always_comb begin
        w_data_next = r_data_sr;
        w_crc_next  = r_crc_sr;
        for (int i = 0; i < DATA_W; i++) begin
            if (w_sample && r_cnt == CNT_W'((MSB_FIRST != 0) ? (DATA_W - 1 - i) : i))
                w_data_next[i] = bus.in_data;
        end
        for (int i = 0; i < CRC_W; i++) begin
            if (w_sample && r_cnt == CNT_W'(DATA_W + ((MSB_FIRST != 0) ? (CRC_W - 1 - i) : i)))
                w_crc_next[i] = bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_data_sr <= '0;
            r_crc_sr  <= '0;
        end else if (bus.clear) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_data_sr <= '0;
            r_crc_sr  <= '0;
        end else if (w_sample) begin
            if (w_last) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_data_sr <= '0;
                r_crc_sr  <= '0;
            end else begin
                r_state   <= S_SHIFT;
                r_cnt     <= (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
                r_data_sr <= w_data_next;
                r_crc_sr  <= w_crc_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_crc_data  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_data      <= w_data_next;
                r_crc_data  <= w_crc_next;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (bus.clear)
                r_overrun <= 1'b0;
            else if (w_complete && r_out_valid && !bus.out_ready)
                r_overrun <= 1'b1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.data      = r_data;
    assign bus.CRC_data  = r_crc_data;
    assign bus.overrun   = r_overrun;

`ifdef DATA_FRAME_SR_CRC_CHECK_EN
    if (CRC_W != 16) begin : g_crc_w_check
        $error("data_frame_sr: CRC_W must be 16 when the CRC check is enabled");
    end

    logic [15:0] r_crc;
    logic        r_crc_ok;
    logic [15:0] w_crc_step;
    logic        w_crc_match;
    logic        w_data_bit;

    assign w_data_bit = (r_cnt < CNT_W'(DATA_W));

    // First-arrived received CRC bit is compared against computed bit 15.
    always_comb begin
        w_crc_step  = {r_crc[14:0], 1'b0} ^ ((bus.in_data ^ r_crc[15]) ? 16'h1021 : 16'h0000);
        w_crc_match = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (w_crc_next[(MSB_FIRST != 0) ? (15 - i) : i] != r_crc[15 - i])
                w_crc_match = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc    <= 16'h0000;
            r_crc_ok <= 1'b0;
        end else begin
            if (bus.clear || (w_sample && w_last))
                r_crc <= 16'h0000;
            else if (w_sample && w_data_bit)
                r_crc <= w_crc_step;

            if (w_load)
                r_crc_ok <= w_crc_match;
        end
    end

    assign bus.crc_ok = r_crc_ok;
`else
    assign bus.crc_ok = 1'b1;
`endif

endmodule
`default_nettype wire
